mux_arbiter: RTL

Two-requester round-robin arbiter that owns the select line of the 2:1 `mux` (`Y = S ? B : A`). It decides which source, A or B, is driven onto `Y`, and returns a grant to that requester. A bounded hold time keeps one requester from starving the other. All outputs are registered, and the block sits directly in front of the `mux` `S` input.

---
 rtl/mux_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter driving the select line of a 2:1 mux.
// Hold counter bounds ownership while the other side waits; all outputs are registered.
module mux_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CW       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic REQ_A,
  input  logic REQ_B,
  output logic GNT_A,
  output logic GNT_B,
  output logic S,
  output logic BUSY
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  localparam logic [CW-1:0] HOLD = CW'(HOLD_MAX);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;  // 0 = A served last, 1 = B served last
  logic          gnt_a_q, gnt_a_d;
  logic          gnt_b_q, gnt_b_d;
  logic          s_q, s_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (REQ_A && REQ_B) state_d = last_q ? OWN_A : OWN_B;
        else if (REQ_A)     state_d = OWN_A;
        else if (REQ_B)     state_d = OWN_B;
      end
      OWN_A: begin
        if (!REQ_A)                      state_d = REQ_B ? OWN_B : IDLE;
        else if (REQ_B && cnt_q == HOLD) state_d = OWN_B;
      end
      OWN_B: begin
        if (!REQ_B)                      state_d = REQ_A ? OWN_A : IDLE;
        else if (REQ_A && cnt_q == HOLD) state_d = OWN_A;
      end
      default: state_d = IDLE;
    endcase

    // A new owner starts its hold at 1; a staying owner counts up and saturates.
    if (state_d != IDLE && state_d != state_q) cnt_d = ONE;
    else if (state_d != IDLE && cnt_q != HOLD) cnt_d = cnt_q + ONE;

    if (state_d == OWN_A) last_d = 1'b0;
    if (state_d == OWN_B) last_d = 1'b1;

    gnt_a_d = (state_d == OWN_A);
    gnt_b_d = (state_d == OWN_B);
    // Select keeps its value in IDLE so the mux output never swings to the other source.
    s_d     = gnt_b_d ? 1'b1 : (gnt_a_d ? 1'b0 : s_q);
    busy_d  = gnt_a_d | gnt_b_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      s_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT_A = gnt_a_q;
  assign GNT_B = gnt_b_q;
  assign S     = s_q;
  assign BUSY  = busy_q;

endmodule
